// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot frame buffer slice.
//   H_ACTIVE / V_ACTIVE : visible raster size in pixels / lines
//   PIXEL_W             : stored colour width {R[2:0],G[2:0],B[2:0]}
//   IN_W                : width of the calculator result bus
//   fb_state_t          : frame buffer fill state
package mandel_pkg;

  localparam int unsigned H_ACTIVE = 32;
  localparam int unsigned V_ACTIVE = 24;
  localparam int unsigned PIXEL_W  = 9;
  localparam int unsigned IN_W     = 32;

  typedef enum logic [1:0] {
    CLEAR,
    FILL,
    DONE
  } fb_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y address counter.
//   clk, reset : clock and synchronous active-high reset
//   en         : advance one pixel (x first, then y)
//   clr        : return to (0,0); has priority over en
//   x, y       : current column / row
//   wrap       : asserted while positioned on the last pixel (H-1,V-1)
module raster_counter #(
  parameter int unsigned H  = 32,
  parameter int unsigned V  = 24,
  parameter int unsigned XW = $clog2(H),
  parameter int unsigned YW = $clog2(V)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          wrap
);

  logic x_last;

  assign x_last = (x == XW'(H - 1));
  assign wrap   = x_last && (y == YW'(V - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_last) begin
        x <= '0;
        y <= wrap ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/mandel_frame_buffer.sv
// Pixel store between the Mandelbrot calculator and the VGA driver.
// Clears memory to black after reset, then stores one result per handshake
// in raster order, holds the finished frame until restart, and serves
// registered (latency 1) random-access reads to the scan side.
//   clk, reset        : 25 MHz pixel clock, synchronous active-high reset
//   wr_valid/wr_ready : calculator result handshake; wr_data[PIXEL_W-1:0] stored
//   restart           : one-cycle pulse starting a new fill (memory kept)
//   frame_done        : every pixel of the current frame written
//   clearing          : post-reset clear in progress
//   fill_count        : pixels written in the current frame
//   rd_en/rd_x/rd_y   : scan-side read request
//   rd_data/rd_valid  : read result, one cycle after rd_en
module mandel_frame_buffer
  import mandel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = mandel_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = mandel_pkg::V_ACTIVE,
  parameter int unsigned PIXEL_W  = mandel_pkg::PIXEL_W,
  parameter int unsigned IN_W     = mandel_pkg::IN_W
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wr_valid,
  input  logic [IN_W-1:0]                          wr_data,
  output logic                                     wr_ready,
  input  logic                                     restart,
  output logic                                     frame_done,
  output logic                                     clearing,
  output logic [$clog2(H_ACTIVE*V_ACTIVE+1)-1:0]   fill_count,
  input  logic                                     rd_en,
  input  logic [$clog2(H_ACTIVE)-1:0]              rd_x,
  input  logic [$clog2(V_ACTIVE)-1:0]              rd_y,
  output logic [PIXEL_W-1:0]                       rd_data,
  output logic                                     rd_valid
);

  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned XW   = $clog2(H_ACTIVE);
  localparam int unsigned YW   = $clog2(V_ACTIVE);
  localparam int unsigned CW   = $clog2(NPIX + 1);

  fb_state_t state, state_next;

  logic [XW-1:0]      wx;
  logic [YW-1:0]      wy;
  logic               wrap;
  logic               accept;
  logic               restart_hit;
  logic               ctr_en;
  logic               mem_we;
  logic [PIXEL_W-1:0] wdata;
  logic [AW-1:0]      waddr;
  logic [AW-1:0]      raddr;
  logic               rd_hit;
  logic               unused_wr_hi;

  logic [PIXEL_W-1:0] mem [NPIX];

  // Single counter serves both the clear sweep and the fill; clr wins over en,
  // so a restart coincident with an accept rewinds after the write lands.
  raster_counter #(
    .H (H_ACTIVE),
    .V (V_ACTIVE)
  ) u_wr_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (ctr_en),
    .clr   (restart_hit),
    .x     (wx),
    .y     (wy),
    .wrap  (wrap)
  );

  always_comb begin
    state_next  = state;
    wr_ready    = 1'b0;
    accept      = 1'b0;
    restart_hit = 1'b0;
    ctr_en      = 1'b0;
    mem_we      = 1'b0;
    wdata       = '0;
    unique case (state)
      CLEAR: begin
        ctr_en = 1'b1;
        mem_we = 1'b1;
        if (wrap) state_next = FILL;
      end
      FILL: begin
        wr_ready    = 1'b1;
        accept      = wr_valid;
        restart_hit = restart;
        ctr_en      = wr_valid;
        mem_we      = wr_valid;
        wdata       = wr_data[PIXEL_W-1:0];
        if (wr_valid && wrap) state_next = DONE;
        if (restart) state_next = FILL;
      end
      DONE: begin
        restart_hit = restart;
        if (restart) state_next = FILL;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  assign clearing   = (state == CLEAR);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset || restart_hit) fill_count <= '0;
    else if (accept)          fill_count <= fill_count + CW'(1);
  end

  assign waddr = AW'(wy) * AW'(H_ACTIVE) + AW'(wx);
  assign raddr = AW'(rd_y) * AW'(H_ACTIVE) + AW'(rd_x);

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  assign rd_hit = rd_en
               && ({1'b0, rd_x} < (XW + 1)'(H_ACTIVE))
               && ({1'b0, rd_y} < (YW + 1)'(V_ACTIVE))
               && (state != CLEAR);

  // Registered read sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_hit ? mem[raddr] : '0;
    end
  end

  assign unused_wr_hi = ^wr_data[IN_W-1:PIXEL_W];

endmodule

// File: tb/tb_mandel_frame_buffer.sv
// Scoreboard bench for mandel_frame_buffer: read expectations are queued at
// issue time and popped by a monitor whenever rd_valid is seen.
module tb_mandel_frame_buffer;

  localparam int H = 32;
  localparam int V = 24;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        restart;
  logic        frame_done;
  logic        clearing;
  logic [9:0]  fill_count;
  logic        rd_en;
  logic [4:0]  rd_x;
  logic [4:0]  rd_y;
  logic [8:0]  rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [8:0] model [N];

  always #20 clk = ~clk;

  mandel_frame_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .restart    (restart),
    .frame_done (frame_done),
    .clearing   (clearing),
    .fill_count (fill_count),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic monitor;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected actual_valid=1 required_valid=0");
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data x=%0d y=%0d actual=%0h required=%0h", rd_x, rd_y, rd_data, e);
          end
        end
      end
    end
  endtask

  task automatic rd_issue(input int x, input int y, input logic [8:0] e);
    rd_en = 1'b1;
    rd_x  = 5'(x);
    rd_y  = 5'(y);
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd_frame;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        rd_issue(x, y, model[y * H + x]);
    tick();
  endtask

  task automatic wr(input logic [31:0] d, input int addr);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    model[addr] = d[8:0];
  endtask

  task automatic pulse_restart;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // Counts negedges with clearing high, reading (expected black) meanwhile.
  task automatic wait_clear(output int n);
    n = 0;
    @(negedge clk);
    while (clearing && n < 2000) begin
      n++;
      rd_en = 1'b1;
      rd_x  = 5'(n);
      rd_y  = 5'(n / 32);
      exp_q.push_back(9'd0);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; restart = 1'b0;
    rd_en = 1'b0; rd_x = '0; rd_y = '0;
    for (int i = 0; i < N; i++) model[i] = 9'd0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    chk("rst_clearing", int'(clearing), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_fill_count", int'(fill_count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    wait_clear(n);
    chk("clear_cycles", n, 768);
    chk("post_clear_wr_ready", int'(wr_ready), 1);
    chk("post_clear_fill_count", int'(fill_count), 0);
    tick();
    rd_frame();

    // Full frame, upper data bits set to confirm they are dropped.
    for (int i = 0; i < N; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hABCD_0000 | 32'(i);
      tick();
      model[i] = 9'(i);
      if (i == N - 2) begin
        chk("fill_767_count", int'(fill_count), 767);
        chk("fill_767_done", int'(frame_done), 0);
      end
    end
    chk("frame_done", int'(frame_done), 1);
    chk("frame_fill_count", int'(fill_count), 768);
    chk("done_wr_ready", int'(wr_ready), 0);

    wr_data = 32'h0000_01FF;
    repeat (5) tick();
    wr_valid = 1'b0;
    chk("done_hold_count", int'(fill_count), 768);
    chk("done_hold_flag", int'(frame_done), 1);

    rd_issue(5, 3, 9'd101);
    rd_issue(31, 23, 9'd255);
    rd_issue(0, 24, 9'd0);
    rd_issue(31, 31, 9'd0);
    tick();
    chk("rd_valid_idle", int'(rd_valid), 0);
    rd_frame();

    pulse_restart();
    chk("restart_count", int'(fill_count), 0);
    chk("restart_done", int'(frame_done), 0);
    chk("restart_wr_ready", int'(wr_ready), 1);
    for (int k = 0; k < 100; k++) wr(32'(200 + k), k);
    chk("fill100_count", int'(fill_count), 100);
    pulse_restart();
    chk("restart2_count", int'(fill_count), 0);
    wr(32'h155, 0);
    chk("after_restart_count", int'(fill_count), 1);
    rd_issue(0, 0, 9'h155);
    rd_issue(3, 3, 9'd299);
    rd_issue(4, 3, 9'd100);
    tick();

    // Restart coincident with accept: write lands at (1,0), counters rewind.
    restart = 1'b1; wr_valid = 1'b1; wr_data = 32'h0AA;
    tick();
    restart = 1'b0; wr_valid = 1'b0;
    model[1] = 9'h0AA;
    chk("coincident_count", int'(fill_count), 0);
    wr(32'h033, 0);
    chk("coincident_next_count", int'(fill_count), 1);

    // Same-address read and write: old contents come back.
    wr_valid = 1'b1; wr_data = 32'h0CC;
    rd_en = 1'b1; rd_x = 5'd1; rd_y = 5'd0;
    exp_q.push_back(9'h0AA);
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    model[1] = 9'h0CC;
    rd_issue(1, 0, 9'h0CC);
    rd_issue(0, 0, 9'h033);
    tick();
    chk("rbw_count", int'(fill_count), 2);

    pulse_restart();
    for (int k = 0; k < 400; k++) wr(32'(k + 50), k);
    chk("fill400_count", int'(fill_count), 400);
    reset = 1'b1;
    tick();
    chk("midfill_rst_clearing", int'(clearing), 1);
    chk("midfill_rst_done", int'(frame_done), 0);
    chk("midfill_rst_count", int'(fill_count), 0);
    chk("midfill_rst_wr_ready", int'(wr_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 9'd0;
    wait_clear(n);
    chk("reclear_cycles", n, 768);
    tick();
    rd_frame();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
